// File: rtl/uni_controle_multiciclo_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states,
// instruction opcode/funct fields, ULA operation codes and the mux
// select codes driven onto the datapath.
package uni_controle_pkg;

    typedef enum logic [3:0] {
        S_RESET   = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXECUTE = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ANDIEX  = 4'd11,
        S_IMMWB   = 4'd12,
        S_JUMP    = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ULA_ADD = 3'b010;
    localparam logic [2:0] ULA_SUB = 3'b110;
    localparam logic [2:0] ULA_AND = 3'b000;
    localparam logic [2:0] ULA_OR  = 3'b001;
    localparam logic [2:0] ULA_SLT = 3'b111;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_RESULT = 2'b00;
    localparam logic [1:0] PCSRC_ULAOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/uni_controle_multiciclo_if.sv
// Control bus between the multicycle control unit and its datapath.
//   master: the control unit (reads IR fields, Zero, MemReady; drives strobes)
//   slave : the datapath (drives IR fields, Zero, MemReady; reads strobes)
interface uni_controle_multiciclo_if;
    logic [5:0] OP;
    logic [5:0] Funct;
    logic       Zero;
    logic       MemReady;
    logic       IorD;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ULASrcA;
    logic [1:0] ULASrcB;
    logic [2:0] ULAControl;
    logic [1:0] PCSrc;
    logic       PCEn;
    logic [3:0] Estado;

    modport master (
        input  OP, Funct, Zero, MemReady,
        output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ULASrcA, ULASrcB, ULAControl, PCSrc, PCEn, Estado
    );

    modport slave (
        output OP, Funct, Zero, MemReady,
        input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ULASrcA, ULASrcB, ULAControl, PCSrc, PCEn, Estado
    );
endinterface

// File: rtl/uni_controle_multiciclo_decod_ula.sv
// Combinational R-type decoder: maps Funct to the ULA operation code.
//   funct       in  6  IR[5:0]
//   ula_control out 3  ULA operation (add when funct is unknown)
//   valid       out 1  funct is one of the supported R-type operations
module decod_ula
    import uni_controle_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] ula_control,
    output logic       valid
);

    always_comb begin
        ula_control = ULA_ADD;
        valid       = 1'b1;
        case (funct)
            FUNCT_ADD: ula_control = ULA_ADD;
            FUNCT_SUB: ula_control = ULA_SUB;
            FUNCT_AND: ula_control = ULA_AND;
            FUNCT_OR:  ula_control = ULA_OR;
            FUNCT_SLT: ula_control = ULA_SLT;
            default:   valid       = 1'b0;
        endcase
    end

endmodule

// File: rtl/uni_controle_multiciclo.sv
// Moore control FSM for the multicycle MIPS datapath (ADD/SUB/AND/OR/SLT,
// LW, SW, BEQ, ADDi, ANDi, J), with memory stalls via MemReady.
//   clk   in  rising-edge clock
//   reset in  asynchronous active-high, forces S_RESET
//   bus   master side of the control bus (IR fields, Zero, MemReady in;
//         datapath strobes, mux selects, PCEn and Estado out)
//
// state     | meaning
// S_RESET   | held in reset, every output 0
// S_FETCH   | read IR from mem[PC], PC <= PC + 4 when MemReady
// S_DECODE  | read A/B, ULAOut <= branch target
// S_MEMADR  | ULAOut <= A + SignImm
// S_MEMRD   | Data <= mem[ULAOut], wait for MemReady
// S_MEMWB   | rt <= Data
// S_MEMWR   | mem[ULAOut] <= B, wait for MemReady
// S_EXECUTE | ULAOut <= A op B
// S_ALUWB   | rd <= ULAOut
// S_BRANCH  | compare A/B, PC <= ULAOut if equal
// S_ADDIEX  | ULAOut <= A + SignImm
// S_ANDIEX  | ULAOut <= A & SignImm
// S_IMMWB   | rt <= ULAOut
// S_JUMP    | PC <= jump target
module uni_controle_multiciclo
    import uni_controle_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    uni_controle_multiciclo_if.master bus
);

    state_t     state_q, state_d;
    logic [2:0] dec_ctl;
    logic       dec_valid;
    logic       pc_write;
    logic       branch;

    decod_ula u_decod_ula (
        .funct       (bus.Funct),
        .ula_control (dec_ctl),
        .valid       (dec_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_RESET;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d        = S_RESET;
        bus.IorD       = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.RegDst     = 1'b0;
        bus.MemtoReg   = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.ULASrcA    = 1'b0;
        bus.ULASrcB    = SRCB_REG;
        bus.ULAControl = ULA_ADD;
        bus.PCSrc      = PCSRC_RESULT;
        pc_write       = 1'b0;
        branch         = 1'b0;
        case (state_q)
            S_RESET: begin
                bus.ULAControl = 3'b000;  // fully quiet while in reset
                state_d        = S_FETCH;
            end
            S_FETCH: begin
                bus.ULASrcB = SRCB_FOUR;
                bus.IRWrite = bus.MemReady;
                pc_write    = bus.MemReady;
                state_d     = bus.MemReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                bus.ULASrcB = SRCB_IMM_SH2;
                case (bus.OP)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_ANDI:      state_d = S_ANDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;  // NOP, PC already advanced
                endcase
            end
            S_MEMADR: begin
                bus.ULASrcA = 1'b1;
                bus.ULASrcB = SRCB_IMM;
                state_d     = (bus.OP == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                bus.IorD = 1'b1;
                state_d  = bus.MemReady ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                bus.MemtoReg = 1'b1;
                bus.RegWrite = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWR: begin
                bus.IorD     = 1'b1;
                bus.MemWrite = 1'b1;
                state_d      = bus.MemReady ? S_FETCH : S_MEMWR;
            end
            S_EXECUTE: begin
                bus.ULASrcA    = 1'b1;
                bus.ULAControl = dec_ctl;
                state_d        = dec_valid ? S_ALUWB : S_FETCH;
            end
            S_ALUWB: begin
                bus.RegDst   = 1'b1;
                bus.RegWrite = 1'b1;
                state_d      = S_FETCH;
            end
            S_BRANCH: begin
                bus.ULASrcA    = 1'b1;
                bus.ULAControl = ULA_SUB;
                bus.PCSrc      = PCSRC_ULAOUT;
                branch         = 1'b1;
                state_d        = S_FETCH;
            end
            S_ADDIEX: begin
                bus.ULASrcA = 1'b1;
                bus.ULASrcB = SRCB_IMM;
                state_d     = S_IMMWB;
            end
            S_ANDIEX: begin
                bus.ULASrcA    = 1'b1;
                bus.ULASrcB    = SRCB_IMM;
                bus.ULAControl = ULA_AND;
                state_d        = S_IMMWB;
            end
            S_IMMWB: begin
                bus.RegWrite = 1'b1;
                state_d      = S_FETCH;
            end
            S_JUMP: begin
                bus.PCSrc = PCSRC_JUMP;
                pc_write  = 1'b1;
                state_d   = S_FETCH;
            end
            default: state_d = S_RESET;
        endcase
    end

    assign bus.PCEn   = pc_write | (branch & bus.Zero);
    assign bus.Estado = state_q;

endmodule

// File: tb/tb_uni_controle_multiciclo.sv
module tb_uni_controle_multiciclo;
    import uni_controle_pkg::*;

    typedef struct packed {
        logic [3:0]  st;
        logic        mr;
        logic [14:0] o;
    } row_t;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;
    row_t q[$];
    logic [5:0] cur_op, cur_fn;
    logic       cur_z;

    uni_controle_multiciclo_if bus ();

    uni_controle_multiciclo dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ULASrcA,
    //  ULASrcB, ULAControl, PCSrc, PCEn}
    function automatic logic [14:0] ov(logic iord, logic mw, logic irw, logic rd,
                                       logic m2r, logic rw, logic sa, logic [1:0] sb,
                                       logic [2:0] ctl, logic [1:0] pcs, logic pcen);
        return {iord, mw, irw, rd, m2r, rw, sa, sb, ctl, pcs, pcen};
    endfunction

    function automatic logic [14:0] outs();
        return {bus.IorD, bus.MemWrite, bus.IRWrite, bus.RegDst, bus.MemtoReg,
                bus.RegWrite, bus.ULASrcA, bus.ULASrcB, bus.ULAControl, bus.PCSrc,
                bus.PCEn};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input state_t st, input logic mr, input logic [14:0] o);
        q.push_back('{st: st, mr: mr, o: o});
    endtask

    // Reference model: the expected cycle-by-cycle trace of one instruction,
    // with sf MemReady=0 cycles in fetch and sm in the memory access.
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                         input int sf, input int sm);
        logic       known;
        logic [2:0] rctl;
        q.delete();
        cur_op = op; cur_fn = fn; cur_z = z;
        for (int i = 0; i < sf; i++)
            push(S_FETCH, 1'b0, ov(0,0,0,0,0,0,0,2'b01,3'b010,2'b00,0));
        push(S_FETCH, 1'b1, ov(0,0,1,0,0,0,0,2'b01,3'b010,2'b00,1));
        push(S_DECODE, 1'($urandom), ov(0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0));
        case (op)
            6'b100011: begin
                push(S_MEMADR, 1'($urandom), ov(0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0));
                for (int i = 0; i < sm; i++)
                    push(S_MEMRD, 1'b0, ov(1,0,0,0,0,0,0,2'b00,3'b010,2'b00,0));
                push(S_MEMRD, 1'b1, ov(1,0,0,0,0,0,0,2'b00,3'b010,2'b00,0));
                push(S_MEMWB, 1'($urandom), ov(0,0,0,0,1,1,0,2'b00,3'b010,2'b00,0));
            end
            6'b101011: begin
                push(S_MEMADR, 1'($urandom), ov(0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0));
                for (int i = 0; i < sm; i++)
                    push(S_MEMWR, 1'b0, ov(1,1,0,0,0,0,0,2'b00,3'b010,2'b00,0));
                push(S_MEMWR, 1'b1, ov(1,1,0,0,0,0,0,2'b00,3'b010,2'b00,0));
            end
            6'b000000: begin
                known = 1'b1;
                case (fn)
                    6'd32:   rctl = 3'b010;
                    6'd34:   rctl = 3'b110;
                    6'd36:   rctl = 3'b000;
                    6'd37:   rctl = 3'b001;
                    6'd42:   rctl = 3'b111;
                    default: begin rctl = 3'b010; known = 1'b0; end
                endcase
                push(S_EXECUTE, 1'($urandom), ov(0,0,0,0,0,0,1,2'b00,rctl,2'b00,0));
                if (known)
                    push(S_ALUWB, 1'($urandom), ov(0,0,0,1,0,1,0,2'b00,3'b010,2'b00,0));
            end
            6'b000100:
                push(S_BRANCH, 1'($urandom), ov(0,0,0,0,0,0,1,2'b00,3'b110,2'b01,z));
            6'b001000: begin
                push(S_ADDIEX, 1'($urandom), ov(0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0));
                push(S_IMMWB, 1'($urandom), ov(0,0,0,0,0,1,0,2'b00,3'b010,2'b00,0));
            end
            6'b001100: begin
                push(S_ANDIEX, 1'($urandom), ov(0,0,0,0,0,0,1,2'b10,3'b000,2'b00,0));
                push(S_IMMWB, 1'($urandom), ov(0,0,0,0,0,1,0,2'b00,3'b010,2'b00,0));
            end
            6'b000010:
                push(S_JUMP, 1'($urandom), ov(0,0,0,0,0,0,0,2'b00,3'b010,2'b10,1));
            default: ;
        endcase
    endtask

    task automatic run_q(input string tag);
        row_t   r;
        state_t s;
        for (int i = 0; i < q.size(); i++) begin
            r = q[i];
            s = state_t'(r.st);
            @(negedge clk);
            if (i == 0) begin
                bus.OP = cur_op; bus.Funct = cur_fn; bus.Zero = cur_z;
            end
            bus.MemReady = r.mr;
            #1;
            chk($sformatf("%s c%0d estado(%s)", tag, i, s.name()), 16'(bus.Estado), 16'(r.st));
            chk($sformatf("%s c%0d outputs(%s)", tag, i, s.name()), 16'(outs()), 16'(r.o));
        end
    endtask

    task automatic chk_reset_quiet(input string tag);
        chk({tag, " estado"}, 16'(bus.Estado), 16'(S_RESET));
        chk({tag, " outputs"}, 16'(outs()), 16'h0000);
        chk({tag, " memwrite"}, 16'(bus.MemWrite), 16'h0000);
    endtask

    initial begin
        logic [5:0] ops [8];
        logic [5:0] fns [5];
        logic [5:0] op, fn;
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                6'b001000, 6'b001100, 6'b000010, 6'b111111};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

        reset = 1'b1;
        bus.OP = '0; bus.Funct = '0; bus.Zero = 1'b0; bus.MemReady = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            chk_reset_quiet("por");
        end
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            build(6'b000000, fns[i], 1'b0, 0, 0);
            run_q($sformatf("rtype%0d", i));
        end
        build(6'b000000, 6'b000001, 1'b0, 0, 0); run_q("rtype_badfn");
        build(6'b100011, 6'd0, 1'b0, 0, 2);      run_q("lw_stall2");
        build(6'b000100, 6'd0, 1'b1, 0, 0);      run_q("beq_taken");
        build(6'b000100, 6'd0, 1'b0, 0, 0);      run_q("beq_not");
        build(6'b000010, 6'd0, 1'b0, 0, 0);      run_q("jump");
        build(6'b111111, 6'd0, 1'b0, 0, 0);      run_q("illegal");
        build(6'b001100, 6'd0, 1'b0, 3, 0);      run_q("andi_stall3");
        build(6'b001000, 6'd0, 1'b0, 0, 0);      run_q("addi");
        build(6'b101011, 6'd0, 1'b0, 0, 1);      run_q("sw_stall1");

        // Reset in the middle of a stalled store.
        build(6'b101011, 6'd0, 1'b0, 0, 2);
        void'(q.pop_back());
        void'(q.pop_back());
        run_q("sw_pre_reset");
        #2 reset = 1'b1;
        #1 chk_reset_quiet("rst_async");
        @(negedge clk);
        bus.MemReady = 1'b1;
        #1 chk_reset_quiet("rst_held");
        @(negedge clk);
        reset = 1'b0;
        build(6'b000100, 6'd0, 1'b0, 0, 0);
        run_q("after_reset");

        for (int n = 0; n < 40; n++) begin
            op = ops[$urandom_range(7)];
            if (op == 6'b111111) op = 6'($urandom);
            fn = ($urandom_range(5) == 0) ? 6'($urandom) : fns[$urandom_range(4)];
            build(op, fn, 1'($urandom), $urandom_range(2), $urandom_range(2));
            run_q($sformatf("rnd%0d_op%b", n, op));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uni_controle_multiciclo.md
Name: uni_controle_multiciclo

Overview:
- Moore-style FSM that sequences the multicycle MIPS datapath: one shared ULA, one unified instruction/data memory, and the IR, A, B, ULAOut and Data registers.
- Decodes OP/Funct once per instruction and steps through the fetch, decode, execute, memory and writeback steps.
- Stalls on memory via a ready handshake.
- Supports ADD, SUB, AND, OR, SLT, LW, SW, BEQ, ADDi, ANDi and J.

Parameters:
- none. All encodings are constants in the shared package.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; forces state S_RESET
- OP  in  6  IR[31:26], valid from S_DECODE onward
- Funct  in  6  IR[5:0]
- Zero  in  1  ULA zero flag
- MemReady  in  1  memory has completed the current read or write this cycle
- IorD  out  1  memory address: 0 = PC, 1 = ULAOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  IR load enable
- RegDst  out  1  write register: 1 = rd, 0 = rt
- MemtoReg  out  1  write data: 1 = Data, 0 = ULAOut
- RegWrite  out  1  register file write enable
- ULASrcA  out  1  0 = PC, 1 = A
- ULASrcB  out  2  00 = B, 01 = const 4, 10 = SignImm, 11 = SignImm<<2
- ULAControl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- PCSrc  out  2  00 = ULAResult, 01 = ULAOut, 10 = jump target
- PCEn  out  1  (PCWrite) | (Branch & Zero)
- Estado  out  4  current state, for debug

Behaviour:
- State register with async reset to S_RESET. In S_RESET every output is 0. S_RESET always goes to S_FETCH.
- Defaults in every state: all strobes 0, ULAControl 010, ULASrcB 00, PCSrc 00, IorD 0, RegDst 0, MemtoReg 0. Each state below lists only what differs.
- S_FETCH: ULASrcB 01, add. IRWrite = PCWrite = MemReady. Stays in S_FETCH while MemReady = 0, else goes to S_DECODE.
- S_DECODE: ULASrcB 11 (branch target precomputed into ULAOut). Next state by OP:
  - 100011 or 101011 -> S_MEMADR
  - 000000 -> S_EXECUTE
  - 000100 -> S_BRANCH
  - 001000 -> S_ADDIEX
  - 001100 -> S_ANDIEX
  - 000010 -> S_JUMP
  - any other OP -> S_FETCH (executes as a NOP; PC already advanced)
- S_MEMADR: ULASrcA 1, ULASrcB 10, add. Goes to S_MEMRD if OP = LW, else S_MEMWR.
- S_MEMRD: IorD 1. Waits on MemReady, then goes to S_MEMWB.
- S_MEMWB: RegDst 0, MemtoReg 1, RegWrite 1. Goes to S_FETCH.
- S_MEMWR: IorD 1, MemWrite 1 held until MemReady. Goes to S_FETCH when MemReady = 1.
- S_EXECUTE: ULASrcA 1, ULASrcB 00. ULAControl from Funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111. Goes to S_ALUWB. An unknown Funct goes to S_FETCH with no writeback.
- S_ALUWB: RegDst 1, MemtoReg 0, RegWrite 1. Goes to S_FETCH.
- S_BRANCH: ULASrcA 1, ULASrcB 00, sub, PCSrc 01, Branch 1, so PCEn = Zero. Goes to S_FETCH.
- S_ADDIEX: ULASrcA 1, ULASrcB 10, add. Goes to S_IMMWB.
- S_ANDIEX: same as S_ADDIEX but ULAControl 000. Goes to S_IMMWB.
- S_IMMWB: RegDst 0, MemtoReg 0, RegWrite 1. Goes to S_FETCH.
- S_JUMP: PCSrc 10, PCWrite 1. Goes to S_FETCH.
- Cycles per instruction with MemReady tied to 1:
  - 3: beq, j
  - 4: R-type, sw, addi, andi
  - 5: lw
  - Each MemReady = 0 cycle adds one cycle.
- Outputs are combinational from the state (plus MemReady, Funct and Zero where stated above). There are no latches and every case has a default.
- Reset asserted mid-instruction: all strobes drop to 0 immediately (asynchronously); no partial register or memory write completes after reset asserts.
- Undefined state encodings go to S_RESET.

Decomposition:
- Package uni_controle_pkg holds:
  - the state enum (4-bit, 14 states);
  - OP and Funct constants;
  - ULAControl codes;
  - ULASrcB and PCSrc codes.
- One sub-module, decod_ula: a combinational Funct -> ULAControl map with a valid flag, instantiated inside the FSM for S_EXECUTE.

Test Plan:
- Reset pulse mid-S_MEMWR, then release with MemReady = 1:
  - while reset is high: MemWrite = 0 and Estado = S_RESET;
  - next cycle after release: S_FETCH with IRWrite = 1 and PCEn = 1.
- R-type ADD (OP 000000, Funct 100000), MemReady = 1:
  - state sequence FETCH, DECODE, EXECUTE, ALUWB;
  - in EXECUTE: ULAControl 010;
  - in ALUWB: RegWrite 1 and RegDst 1;
  - repeat for SUB/AND/OR/SLT and check ULAControl 110/000/001/111.
- LW (100011) with MemReady low for 2 cycles in S_MEMRD:
  - total 7 cycles, IorD = 1 throughout MEMRD;
  - S_MEMWB asserts MemtoReg = 1 and RegWrite = 1;
  - no RegWrite in any other state.
- BEQ (000100):
  - Zero = 1 -> PCEn = 1 and PCSrc 01 in S_BRANCH;
  - Zero = 0 -> PCEn = 0;
  - both cases return to S_FETCH after 3 cycles.
- J (000010): S_JUMP asserts PCSrc 10 and PCEn = 1; illegal OP 111111 returns to S_FETCH directly after DECODE with no writes.
- ANDi (001100), FETCH stalled 3 cycles by MemReady = 0:
  - IRWrite and PCEn stay 0 until MemReady = 1;
  - then ANDIEX shows ULAControl 000 and ULASrcB 10;
  - S_IMMWB asserts RegWrite = 1 with RegDst = 0.
